// File: rtl/nibble_to_byte_assembler_if.sv
// Nibble-in / byte-out handshake bundle for the nibble-to-byte assembler.
// The master drives nibbles and out_ready; the slave (the assembler) drives the rest.
interface nibble_to_byte_assembler_if #(
  parameter int CW = 8
);
  logic [3:0]    in_nibble;
  logic          in_valid;
  logic          in_first;
  logic          in_ready;
  logic [7:0]    out_byte;
  logic          out_valid;
  logic          out_ready;
  logic          err;
  logic [CW-1:0] byte_count;

  modport master (
    output in_nibble, in_valid, in_first, out_ready,
    input  in_ready, out_byte, out_valid, err, byte_count
  );

  modport slave (
    input  in_nibble, in_valid, in_first, out_ready,
    output in_ready, out_byte, out_valid, err, byte_count
  );
endinterface

// File: rtl/nibble_to_byte_assembler.sv
// Pairs 4-bit nibbles into bytes behind a one-byte output buffer, with
// in_first-driven resync and a wrap-around delivered-byte counter.
module nibble_to_byte_assembler #(
  parameter bit HI_FIRST = 1'b1,
  parameter int CW       = 8
) (
  input  logic                          clock,
  input  logic                          reset,
  nibble_to_byte_assembler_if.slave     bus
);

  typedef enum logic {S_FIRST, S_SECOND} state_e;

  state_e        st_q, st_d;
  logic [3:0]    hold_q, hold_d;
  logic [7:0]    obuf_q, obuf_d;
  logic          out_valid_q, out_valid_d;
  logic          err_q, err_d;
  logic [CW-1:0] count_q, count_d;

  logic in_ready;
  logic in_xfer;
  logic out_xfer;

  // A second nibble may only land when the buffer is free or draining now.
  assign in_ready = !(st_q == S_SECOND && out_valid_q && !bus.out_ready);
  assign in_xfer  = bus.in_valid && in_ready;
  assign out_xfer = out_valid_q && bus.out_ready;

  always_comb begin
    st_d        = st_q;
    hold_d      = hold_q;
    obuf_d      = obuf_q;
    out_valid_d = out_valid_q;
    err_d       = 1'b0;
    count_d     = count_q;

    if (out_xfer) begin
      out_valid_d = 1'b0;
      count_d     = count_q + CW'(1);
    end

    if (in_xfer) begin
      case (st_q)
        S_FIRST: begin
          hold_d = bus.in_nibble;
          st_d   = S_SECOND;
        end
        S_SECOND: begin
          if (bus.in_first) begin
            // Framing slip: restart the pair from this nibble.
            hold_d = bus.in_nibble;
            err_d  = 1'b1;
          end else begin
            obuf_d      = HI_FIRST ? {hold_q, bus.in_nibble} : {bus.in_nibble, hold_q};
            out_valid_d = 1'b1;
            st_d        = S_FIRST;
          end
        end
        default: st_d = S_FIRST;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      st_q        <= S_FIRST;
      hold_q      <= '0;
      obuf_q      <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
      count_q     <= '0;
    end else begin
      st_q        <= st_d;
      hold_q      <= hold_d;
      obuf_q      <= obuf_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
      count_q     <= count_d;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_byte   = obuf_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.err        = err_q;
  assign bus.byte_count = count_q;

endmodule
